// File: rtl/obstacle_spawner.sv
// rtl/obstacle_spawner.sv - two-slot obstacle scroller with LFSR respawn, flicker and score
module obstacle_spawner #(
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int          SPEED       = 4,
    parameter int          SPAWN_X     = 740,
    parameter int          GAP         = 320,
    parameter int          FLICK_TICKS = 8,
    parameter int          SCORE_MAX   = 999
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       frame_tick,
    input  logic       start,
    input  logic       game_over,
    output logic [1:0] obs1_type,
    output logic [1:0] obs2_type,
    output logic [1:0] obs1_pos,
    output logic [1:0] obs2_pos,
    output logic [9:0] obs1_x,
    output logic [9:0] obs2_x,
    output logic       flick1,
    output logic       flick2,
    output logic       running,
    output logic [9:0] score
);
    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_FROZEN = 2'd2;

    localparam int         CW       = $clog2(FLICK_TICKS + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(FLICK_TICKS - 1);
    localparam logic [9:0] X_SPAWN  = 10'(SPAWN_X);
    localparam logic [9:0] X_SPEED  = 10'(SPEED);
    localparam logic [9:0] X_ACT2   = 10'(SPAWN_X - GAP);

    logic [1:0]    state;
    logic [15:0]   lfsr;
    logic [15:0]   lfsr_next;
    logic [CW-1:0] cnt1;
    logic [CW-1:0] cnt2;
    logic          slot2_active;

    logic          respawn1;
    logic          respawn2;
    logic          activate2;
    logic [10:0]   score_sum;
    logic [9:0]    score_next;
    logic [1:0]    spawn1_type;
    logic [1:0]    spawn1_pos;
    logic [1:0]    spawn2_type;
    logic [1:0]    spawn2_pos;

    function automatic logic [1:0] pos_map(input logic [1:0] raw);
        pos_map = (raw == 2'd3) ? 2'd1 : raw;
    endfunction

    // Galois form, feedback bit folded into taps 16,14,13,11
    always_comb begin
        lfsr_next = {lfsr[0], lfsr[15], lfsr[14] ^ lfsr[0], lfsr[13] ^ lfsr[0],
                     lfsr[12], lfsr[11] ^ lfsr[0], lfsr[10:1]};
    end

    always_comb begin
        spawn1_type = lfsr[3:2];
        spawn1_pos  = pos_map(lfsr[1:0]);
        spawn2_type = lfsr[7:6];
        spawn2_pos  = pos_map(lfsr[5:4]);
        respawn1    = (obs1_x <= X_SPEED);
        respawn2    = slot2_active && (obs2_x <= X_SPEED);
        activate2   = !slot2_active && (obs1_x <= X_ACT2);
        score_sum   = {1'b0, score} + 11'(respawn1) + 11'(respawn2);
        score_next  = (score_sum >= 11'(SCORE_MAX)) ? 10'(SCORE_MAX) : score_sum[9:0];
    end

    assign running = (state == S_RUN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            lfsr         <= SEED;
            obs1_x       <= X_SPAWN;
            obs2_x       <= X_SPAWN;
            obs1_type    <= 2'd0;
            obs2_type    <= 2'd0;
            obs1_pos     <= 2'd0;
            obs2_pos     <= 2'd0;
            flick1       <= 1'b0;
            flick2       <= 1'b0;
            cnt1         <= '0;
            cnt2         <= '0;
            slot2_active <= 1'b0;
            score        <= 10'd0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state     <= S_RUN;
                        obs1_x    <= X_SPAWN;
                        obs1_type <= spawn1_type;
                        obs1_pos  <= spawn1_pos;
                        cnt1      <= '0;
                        cnt2      <= '0;
                        flick1    <= 1'b0;
                        flick2    <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (game_over) begin
                        state <= S_FROZEN;
                    end else if (frame_tick) begin
                        if (respawn1) begin
                            obs1_x    <= X_SPAWN;
                            obs1_type <= spawn1_type;
                            obs1_pos  <= spawn1_pos;
                            cnt1      <= '0;
                            flick1    <= 1'b0;
                        end else begin
                            obs1_x <= obs1_x - X_SPEED;
                            if (cnt1 == CNT_LAST) begin
                                cnt1   <= '0;
                                flick1 <= ~flick1;
                            end else begin
                                cnt1 <= cnt1 + 1'b1;
                            end
                        end
                        // slot 2 spawns in place on activation and starts moving next tick
                        if (activate2 || respawn2) begin
                            slot2_active <= 1'b1;
                            obs2_x       <= X_SPAWN;
                            obs2_type    <= spawn2_type;
                            obs2_pos     <= spawn2_pos;
                            cnt2         <= '0;
                            flick2       <= 1'b0;
                        end else if (slot2_active) begin
                            obs2_x <= obs2_x - X_SPEED;
                            if (cnt2 == CNT_LAST) begin
                                cnt2   <= '0;
                                flick2 <= ~flick2;
                            end else begin
                                cnt2 <= cnt2 + 1'b1;
                            end
                        end
                        score <= score_next;
                    end
                end
                S_FROZEN: begin
                    state <= S_FROZEN;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
